// File: rtl/usbfs_tx_pkt_pkg.sv
// Shared USB full-speed TX definitions: PID bytes, packet kinds, FSM states and the CRC16 step.
package usbfsPkg;

  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    KindData  = 2'd0,
    KindAck   = 2'd1,
    KindNak   = 2'd2,
    KindStall = 2'd3
  } tx_kind_e;

  typedef enum logic [2:0] {
    StIdle,
    StPid,
    StData,
    StCrcLo,
    StCrcHi
  } tx_state_e;

  // Bits enter LSB first, so the shift register runs right with the bit-reversed polynomial.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] poly_r;
    logic [15:0] c;
    for (int i = 0; i < 16; i++) poly_r[i] = CRC16_POLY[15-i];
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ poly_r) : (c >> 1);
    return c;
  endfunction

  function automatic logic [7:0] pid_byte(input tx_kind_e kind, input logic data1);
    case (kind)
      KindData: return data1 ? PID_DATA1 : PID_DATA0;
      KindAck:  return PID_ACK;
      KindNak:  return PID_NAK;
      default:  return PID_STALL;
    endcase
  endfunction

endpackage

// File: rtl/usbfs_tx_pkt_if.sv
// Serializer byte stream plus endpoint payload write port of the TX packet assembler.
interface usbfs_tx_pkt_if #(
  parameter int unsigned MAX_PKT = 8
);
  localparam int unsigned IDX_W = $clog2(MAX_PKT);

  logic             tx_valid;
  logic [7:0]       tx_data;
  logic             tx_last;
  logic             tx_ready;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [7:0]       wr_byte;

  modport master (
    output tx_valid, tx_data, tx_last,
    input  tx_ready, wr_en, wr_idx, wr_byte
  );

  modport slave (
    input  tx_valid, tx_data, tx_last,
    output tx_ready, wr_en, wr_idx, wr_byte
  );

endinterface

// File: rtl/usbfs_crc16.sv
// Byte-wide USB CRC16 register (reflected 0x8005, init 0xFFFF); shared with the RX checker.
module usbfs_crc16
  import usbfsPkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_adv,
  input  logic [7:0]  i_data,
  output logic [15:0] o_crc
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (i_clr) begin
      crc_d = CRC16_INIT;
    end else if (i_adv) begin
      crc_d = crc16_byte(crc_q, i_data);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      crc_q <= CRC16_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign o_crc = crc_q;

endmodule

// File: rtl/usbfs_tx_pkt.sv
// USB FS TX packet assembler: PID, buffered payload, complemented CRC16 to the serializer.
// Optional USBFS_TX_PKT_PKTCNT_EN adds o_pktCnt, a count of completed DATAx packets.
module usbfs_tx_pkt
  import usbfsPkg::*;
#(
  parameter int unsigned MAX_PKT = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_txReq,
  input  logic [1:0]  i_txKind,
  input  logic        i_toggleClr,
  input  logic        i_toggleAdv,
  output logic        o_txBusy,
  output logic        o_etTxAccepted,
`ifdef USBFS_TX_PKT_PKTCNT_EN
  output logic [15:0] o_pktCnt,
`endif
  usbfs_tx_pkt_if.master tx_if
);

  localparam int unsigned IDX_W = $clog2(MAX_PKT);

  tx_state_e      state_q, state_d;
  tx_kind_e       kind_q, kind_d;
  logic           data1_q, data1_d;
  logic           toggle_q, toggle_d;
  logic [IDX_W:0] wr_count_q, wr_count_d;
  logic [IDX_W:0] rd_idx_q, rd_idx_d;
  logic [7:0]     pkt_buf [MAX_PKT];

  logic           hs;
  logic           start;
  logic           has_byte;
  logic [7:0]     rd_byte;
  logic [IDX_W:0] wr_idx_ext;
  logic           crc_clr;
  logic           crc_adv;
  logic [15:0]    crc;

  assign hs         = tx_if.tx_valid && tx_if.tx_ready;
  assign has_byte   = rd_idx_q < wr_count_q;
  assign rd_byte    = pkt_buf[rd_idx_q[IDX_W-1:0]];
  assign wr_idx_ext = {1'b0, tx_if.wr_idx};
  assign o_txBusy   = (state_q != StIdle);

  usbfs_crc16 u_crc (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (crc_clr),
    .i_adv  (crc_adv),
    .i_data (rd_byte),
    .o_crc  (crc)
  );

  always_comb begin
    state_d          = state_q;
    kind_d           = kind_q;
    data1_d          = data1_q;
    rd_idx_d         = rd_idx_q;
    start            = 1'b0;
    crc_clr          = 1'b0;
    crc_adv          = 1'b0;
    o_etTxAccepted   = 1'b0;
    tx_if.tx_valid   = 1'b0;
    tx_if.tx_data    = 8'h00;
    tx_if.tx_last    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_txReq) begin
          state_d  = StPid;
          kind_d   = tx_kind_e'(i_txKind);
          data1_d  = toggle_q;
          rd_idx_d = '0;
          start    = 1'b1;
          crc_clr  = 1'b1;
        end
      end
      StPid: begin
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = pid_byte(kind_q, data1_q);
        tx_if.tx_last  = (kind_q != KindData);
        if (hs) begin
          if (kind_q == KindData) begin
            o_etTxAccepted = 1'b1;
            state_d        = StData;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        tx_if.tx_valid = 1'b1;
        if (has_byte) begin
          tx_if.tx_data = rd_byte;
          if (hs) begin
            crc_adv  = 1'b1;
            rd_idx_d = rd_idx_q + 1'b1;
            if (rd_idx_d == wr_count_q) state_d = StCrcLo;
          end
        end else begin
          // Empty or exhausted buffer: present the CRC low byte right here, no bubble.
          tx_if.tx_data = ~crc[7:0];
          if (hs) state_d = StCrcHi;
        end
      end
      StCrcLo: begin
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = ~crc[7:0];
        if (hs) state_d = StCrcHi;
      end
      StCrcHi: begin
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = ~crc[15:8];
        tx_if.tx_last  = 1'b1;
        if (hs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_count_d = wr_count_q;
    if (start) wr_count_d = '0;
    if (tx_if.wr_en && (wr_idx_ext >= wr_count_d)) wr_count_d = wr_idx_ext + 1'b1;
  end

  always_comb begin
    toggle_d = toggle_q;
    if (i_toggleClr) begin
      toggle_d = 1'b0;
    end else if (i_toggleAdv) begin
      toggle_d = ~toggle_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      kind_q     <= KindData;
      data1_q    <= 1'b0;
      toggle_q   <= 1'b0;
      wr_count_q <= '0;
      rd_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      data1_q    <= data1_d;
      toggle_q   <= toggle_d;
      wr_count_q <= wr_count_d;
      rd_idx_q   <= rd_idx_d;
    end
  end

  // Payload storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (tx_if.wr_en) pkt_buf[tx_if.wr_idx] <= tx_if.wr_byte;
  end

`ifdef USBFS_TX_PKT_PKTCNT_EN
  logic [15:0] pkt_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pkt_cnt_q <= 16'h0000;
    end else if ((state_q == StCrcHi) && hs) begin
      pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  assign o_pktCnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_usbfs_tx_pkt.sv
// Self-checking bench for usbfs_tx_pkt: randomized serializer backpressure and payloads
// checked against a byte-list model of the packet (PID, payload, complemented CRC16).
module tb_usbfs_tx_pkt;

  localparam int unsigned MAX_PKT = 8;
  localparam int unsigned IDX_W   = $clog2(MAX_PKT);

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_req;
  logic [1:0] tx_kind;
  logic       tog_clr;
  logic       tog_adv;
  logic       busy;
  logic       acc;
`ifdef USBFS_TX_PKT_PKTCNT_EN
  logic [15:0] pkt_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  bit model_tog;
  int model_cnt;

  usbfs_tx_pkt_if #(.MAX_PKT(MAX_PKT)) tx_if ();

  usbfs_tx_pkt #(.MAX_PKT(MAX_PKT)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_txReq        (tx_req),
    .i_txKind       (tx_kind),
    .i_toggleClr    (tog_clr),
    .i_toggleAdv    (tog_adv),
    .o_txBusy       (busy),
    .o_etTxAccepted (acc),
`ifdef USBFS_TX_PKT_PKTCNT_EN
    .o_pktCnt       (pkt_cnt),
`endif
    .tx_if          (tx_if)
  );

  always #5 clk = ~clk;

  // USB CRC16 computed bit by bit, LSB first.
  function automatic logic [15:0] crc_ref(input logic [7:0] d[$]);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < d.size(); i++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ d[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    end
    return c;
  endfunction

  task automatic check_cnt(input string name);
`ifdef USBFS_TX_PKT_PKTCNT_EN
    checks++;
    if (pkt_cnt !== 16'(model_cnt)) begin
      failures++;
      $display("FAIL %s pkt_cnt got=%0d want=%0d", name, pkt_cnt, model_cnt);
    end
`endif
  endtask

  task automatic pulse_tog(input bit clr, input bit adv);
    @(negedge clk);
    tog_clr = clr;
    tog_adv = adv;
    @(negedge clk);
    tog_clr = 1'b0;
    tog_adv = 1'b0;
    if (clr) model_tog = 1'b0;
    else if (adv) model_tog = ~model_tog;
  endtask

  // inject: 0 none, 1 req+toggle pulses mid-packet, 2 req on the final handshake.
  // abort_at: reset when this many bytes have been taken (-1 = never).
  task automatic run_pkt(input int kind, input int nbytes, input bit rand_rdy,
                         input int inject, input int abort_at, input bit inorder);
    logic [7:0] pay[$];
    logic [7:0] exp_q[$];
    logic [15:0] c;
    logic [7:0] prev_data;
    logic       prev_last;
    int pos, wr_n, acc_cnt, cyc, len, idx;
    bit writing, done, wrote, injected, hs, prev_stall, rdy;
    pos = 0; wr_n = 0; acc_cnt = 0; cyc = 0;
    writing = 0; done = 0; injected = 0; prev_stall = 0;
    prev_data = 8'h00; prev_last = 1'b0;
    for (int i = 0; i < nbytes; i++) pay.push_back(inorder ? 8'(i) : 8'($urandom));
    case (kind)
      0:       exp_q.push_back(model_tog ? 8'h4B : 8'hC3);
      1:       exp_q.push_back(8'hD2);
      2:       exp_q.push_back(8'h5A);
      default: exp_q.push_back(8'h1E);
    endcase
    if (kind == 0) begin
      foreach (pay[i]) exp_q.push_back(pay[i]);
      c = crc_ref(pay);
      exp_q.push_back(~c[7:0]);
      exp_q.push_back(~c[15:8]);
    end
    len = exp_q.size();

    @(negedge clk);
    tx_req  = 1'b1;
    tx_kind = 2'(kind);
    tx_if.tx_ready = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || tx_if.tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_before_req busy=%b valid=%b want 0,0", busy, tx_if.tx_valid);
    end
    @(negedge clk);
    tx_req = 1'b0;

    while (!done && cyc < 400) begin
      wrote = 0;
      if (abort_at >= 0 && pos == abort_at) begin
        tx_if.tx_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (tx_if.tx_valid !== 1'b0 || busy !== 1'b0 || tx_if.tx_last !== 1'b0 || acc !== 1'b0)
        begin
          failures++;
          $display("FAIL abort_drop valid=%b busy=%b last=%b acc=%b want all 0",
                   tx_if.tx_valid, busy, tx_if.tx_last, acc);
        end
        model_tog = 1'b0;
        model_cnt = 0;
        check_cnt("abort");
        return;
      end
      if (writing) begin
        rdy = 1'b0;
        idx = inorder ? wr_n : nbytes - 1 - wr_n;
        tx_if.wr_en   = 1'b1;
        tx_if.wr_idx  = IDX_W'(idx);
        tx_if.wr_byte = pay[idx];
        wr_n++;
        wrote = 1;
        if (wr_n == nbytes) writing = 0;
      end else begin
        rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (inject == 1 && !injected && !wrote && pos == 2) begin
        tx_req = 1'b1; tx_kind = 2'd1; tog_clr = 1'b1; tog_adv = 1'b1;
        model_tog = 1'b0;
        injected = 1;
      end
      if (inject == 2 && !injected && !wrote && pos == len - 1) begin
        rdy = 1'b1; tx_req = 1'b1; tx_kind = 2'd0;
        injected = 1;
      end
      tx_if.tx_ready = rdy;
      #1;
      checks++;
      if (tx_if.tx_valid !== 1'b1 || busy !== 1'b1) begin
        failures++;
        $display("FAIL in_packet pos=%0d valid=%b busy=%b want 1,1", pos, tx_if.tx_valid, busy);
      end
      if (prev_stall) begin
        checks++;
        if (tx_if.tx_data !== prev_data || tx_if.tx_last !== prev_last) begin
          failures++;
          $display("FAIL stall_stable pos=%0d data=%h last=%b want %h,%b",
                   pos, tx_if.tx_data, tx_if.tx_last, prev_data, prev_last);
        end
      end
      hs = (tx_if.tx_valid === 1'b1) && rdy;
      if (acc === 1'b1) begin
        acc_cnt++;
        checks++;
        if (!(hs && pos == 0)) begin
          failures++;
          $display("FAIL accept_timing pulse at pos=%0d hs=%b want pos 0 with hs", pos, hs);
        end
      end
      if (hs) begin
        checks++;
        if (tx_if.tx_data !== exp_q[pos] || tx_if.tx_last !== (pos == len - 1)) begin
          failures++;
          $display("FAIL byte[%0d] kind=%0d data=%h last=%b want %h,%b", pos, kind,
                   tx_if.tx_data, tx_if.tx_last, exp_q[pos], (pos == len - 1));
        end
        pos++;
        if (pos == len) done = 1;
        if (pos == 1 && kind == 0 && nbytes > 0) writing = 1;
      end
      prev_stall = (tx_if.tx_valid === 1'b1) && !rdy && !wrote;
      prev_data  = tx_if.tx_data;
      prev_last  = tx_if.tx_last;
      @(negedge clk);
      tx_req = 1'b0; tog_clr = 1'b0; tog_adv = 1'b0; tx_if.wr_en = 1'b0;
      cyc++;
    end
    tx_if.tx_ready = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL timeout kind=%0d got=%0d bytes want %0d", kind, pos, len);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_tog = 1'b0;
      model_cnt = 0;
      return;
    end
    #1;
    checks++;
    if (busy !== 1'b0 || tx_if.tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_after busy=%b valid=%b want 0,0", busy, tx_if.tx_valid);
    end
    checks++;
    if (acc_cnt != ((kind == 0) ? 1 : 0)) begin
      failures++;
      $display("FAIL accept_count got=%0d want=%0d", acc_cnt, (kind == 0) ? 1 : 0);
    end
    if (kind == 0) model_cnt++;
    check_cnt("after_pkt");
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_req = 1'b0; tx_kind = 2'd0; tog_clr = 1'b0; tog_adv = 1'b0;
    tx_if.tx_ready = 1'b0; tx_if.wr_en = 1'b0; tx_if.wr_idx = '0; tx_if.wr_byte = 8'h00;
    model_tog = 1'b0;
    model_cnt = 0;
    repeat (3) @(negedge clk);
    tx_if.tx_ready = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || acc !== 1'b0 || tx_if.tx_valid !== 1'b0 ||
        tx_if.tx_last !== 1'b0 || tx_if.tx_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs busy=%b acc=%b valid=%b last=%b data=%h want all 0",
               busy, acc, tx_if.tx_valid, tx_if.tx_last, tx_if.tx_data);
    end
    check_cnt("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || tx_if.tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_req busy=%b valid=%b want 0,0", busy, tx_if.tx_valid);
    end
    tx_if.tx_ready = 1'b0;
  endtask

  task automatic test_zero_len();
    pulse_tog(1'b1, 1'b0);
    run_pkt(0, 0, 1'b0, 0, -1, 1'b1);
  endtask

  task automatic test_data1();
    pulse_tog(1'b0, 1'b1);
    run_pkt(0, 8, 1'b0, 0, -1, 1'b1);
  endtask

  task automatic test_handshakes();
    for (int k = 1; k < 4; k++) run_pkt(k, 0, 1'b0, 0, -1, 1'b1);
    run_pkt(0, 3, 1'b0, 0, -1, 1'b0);
  endtask

  task automatic test_backpressure();
    run_pkt(0, 8, 1'b1, 0, -1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 1) pulse_tog(1'b0, 1'b1);
      run_pkt(int'($urandom_range(0, 3)) == 0 ? int'($urandom_range(1, 3)) : 0,
              int'($urandom_range(0, MAX_PKT)), 1'b1, 0, -1, 1'(i % 2));
    end
  endtask

  task automatic test_reset_mid();
    pulse_tog(1'b0, 1'b1);
    if (!model_tog) pulse_tog(1'b0, 1'b1);
    run_pkt(0, 8, 1'b0, 0, 4, 1'b1);
    run_pkt(0, 0, 1'b0, 0, -1, 1'b1);
  endtask

  task automatic test_busy_req();
    if (!model_tog) pulse_tog(1'b0, 1'b1);
    run_pkt(0, 5, 1'b1, 1, -1, 1'b0);
    run_pkt(0, 0, 1'b0, 0, -1, 1'b1);
    run_pkt(0, 2, 1'b1, 2, -1, 1'b1);
    run_pkt(1, 0, 1'b0, 2, -1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_zero_len();
    test_data1();
    test_handshakes();
    test_backpressure();
    test_reset_mid();
    test_busy_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/usbfs_tx_pkt.md
Name: usbfs_tx_pkt

Overview:
- Packet assembler directly downstream of the endpoint TX stage.
- Accepts endpoint payload writes (index-addressed) into a MAX_PKT-byte buffer.
- On request, emits a byte stream to the NRZI/bit-stuff serializer: PID, payload, then CRC16 (lo byte, then hi byte). Handshake packets (ACK/NAK/STALL) are PID-only.
- Pulses o_etTxAccepted when a DATAx PID byte is taken by the serializer. The endpoint stage starts writing payload on that pulse.

Parameters:
- MAX_PKT, 8, payload buffer depth in bytes; power of 2, 8..64.
- IDX_W, $clog2(MAX_PKT), write index width; derived, never overridden.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_txReq  in  1  pulse: start a packet; ignored while o_txBusy=1
- i_txKind  in  2  0=DATAx, 1=ACK, 2=NAK, 3=STALL; sampled with i_txReq
- i_toggleClr  in  1  pulse: set data toggle to DATA0 (SETUP received)
- i_toggleAdv  in  1  pulse: flip data toggle (host ACKed the last data packet)
- o_txBusy  out  1  packet in progress
- o_etTxAccepted  out  1  1-cycle pulse when the DATAx PID byte handshakes out
- i_etWrEn  in  1  payload write strobe
- i_etWrIdx  in  IDX_W  payload byte index
- i_etWrByte  in  8  payload byte
- o_txValid  out  1  byte valid to the serializer
- o_txData  out  8  byte to the serializer, LSB first on the wire
- o_txLast  out  1  current byte is the final byte of the packet
- i_txReady  in  1  serializer takes the byte when o_txValid && i_txReady

Behaviour:
- Reset values: all outputs 0, state IDLE, toggle=DATA0, wrCount=0, crc=16'hFFFF. Buffer contents are not reset.
- Reset mid-packet aborts immediately. The stream drops with no o_txLast.

State machine (IDLE, PID, DATA, CRC_LO, CRC_HI):
- IDLE, i_txReq=1: latch kind, clear wrCount, crc=FFFF, go to PID (o_txValid=1 on the next cycle).
- PID, o_txData:
  - DATA0=C3, DATA1=4B, ACK=D2, NAK=5A, STALL=1E.
  - For a handshake kind, o_txLast=1.
- PID on handshake:
  - Handshake kind: go to IDLE.
  - DATAx: pulse o_etTxAccepted, go to DATA.
- DATA, readIdx < wrCount: present buf[readIdx]. On handshake, update crc and increment readIdx.
- DATA, readIdx == wrCount (including 0): go straight to CRC_LO with no bubble. The zero-length packet is therefore PID, CRC_LO, CRC_HI.
- CRC_LO: o_txData = ~crc[7:0].
- CRC_HI: o_txData = ~crc[15:8], o_txLast=1. On handshake, go to IDLE.
- o_txValid stays 1 in PID/DATA/CRC_LO/CRC_HI until the handshake; o_txData is stable while stalled.
- o_txBusy = (state != IDLE).

Payload writes and wrCount:
- On i_etWrEn: buf[i_etWrIdx] = i_etWrByte; wrCount = max(wrCount, i_etWrIdx+1), range 0..MAX_PKT (IDX_W+1 bits).
- Writes are accepted in any state.
- Upstream must finish all writes before the serializer requests the first payload byte (guaranteed: one byte time ≫ MAX_PKT clocks).

CRC16:
- Polynomial 8005, reflected (LSB-first), init FFFF, transmitted complemented.
- One byte per cycle, combinational over 8 bits.

Toggle:
- i_toggleClr has priority over i_toggleAdv.
- The toggle is sampled at PID entry.
- A toggle change during a packet does not alter the PID already in flight.

Simultaneous events:
- i_txReq in the same cycle as the final handshake is ignored; busy is still 1 that cycle.
- A write in the same cycle as a read of the same index: the read returns the old byte.

Optional Feature:
- Macro: USBFS_TX_PKT_PKTCNT_EN.
- Defined: adds output o_pktCnt[15:0], reset 0. It increments on each completed DATAx packet (CRC_HI handshake) and wraps FFFF→0000.
- Undefined: port absent, no counter logic.

Decomposition:
- Package usbfsPkg:
  - PID constants (PID_DATA0/DATA1/ACK/NAK/STALL).
  - txKind enum.
  - CRC16_POLY, CRC16_INIT.
  - State enum.
- Sub-module usbfs_crc16: byte-wide next-state function plus register, with clear and advance inputs. It is reused by the RX checker.

Test Plan:
- Zero-length DATA0: toggleClr, txReq kind=0, no writes, i_txReady=1 → bytes C3,00,00; o_txLast on byte 3; o_etTxAccepted pulses once, coincident with C3.
- 8-byte DATA1: toggleAdv once, writes 00..07 after the accepted pulse → C3→4B, eight payload bytes in order, then CRC bytes matching the bench reference model (reflected 8005, init FFFF, complemented); o_txBusy falls the cycle after the last handshake.
- Handshakes: kind=1/2/3 → single byte D2/5A/1E with o_txLast=1; no o_etTxAccepted; toggle unchanged.
- Backpressure: random i_txReady (50%) during an 8-byte packet → o_txData/o_txLast stable while stalled, identical byte sequence to the ready=1 run.
- Reset at payload byte 3 → o_txValid=0 the next cycle; then zero-length packet → C3,00,00 (toggle reset to DATA0).
- txReq while busy plus simultaneous toggleClr/toggleAdv → request ignored; toggle=DATA0; next packet PID C3.
